// File: rtl/qspi_flash_responder.sv
// Flash-side Quad I/O Fast Read (0xEB) responder: oversamples the SPI pins on the system clock
// and streams nibbles from a synchronous read-only byte memory.
module qspi_flash_responder #(
    parameter int unsigned MEM_AW    = 16,
    parameter int unsigned MODE_CYC  = 2,
    parameter int unsigned DUMMY_CYC = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              fsclk_i,
    input  logic              fcen_i,
    input  logic [3:0]        fdi_i,
    output logic [3:0]        fdo_o,
    output logic              fdoe_o,
    output logic              mem_rd_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic              busy_o,
    output logic              cmd_err_o
);

    localparam logic [7:0] ModeLast  = 8'(MODE_CYC - 1);
    localparam logic [7:0] DummyLast = 8'(DUMMY_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StMode,
        StDummy,
        StData,
        StIgnore
    } state_e;

    state_e state_q, state_d;

    logic              sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic              cen_meta_q, cen_sync_q;
    logic [3:0]        fdi_meta_q, fdi_sync_q;
    logic [1:0]        sync_ok_q;
    logic              armed_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        shift_q;
    logic              nib_lo_q, nib_lo_d;
    logic              load_q;
    logic [3:0]        fdo_q, fdo_d;
    logic              fdoe_q, fdoe_d;
    logic              mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              cmd_err_q, cmd_err_d;

    logic       sclk_rise, sclk_fall;
    logic [7:0] opcode_shift;

    assign sclk_rise    = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall    = ~sclk_sync_q & sclk_prev_q;
    assign opcode_shift = {opcode_q, fdi_sync_q[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        nib_lo_d   = nib_lo_q;
        fdo_d      = fdo_q;
        fdoe_d     = fdoe_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        cmd_err_d  = 1'b0;

        // Chip-enable high beats any clock edge seen in the same cycle.
        if (cen_sync_q) begin
            state_d  = StIdle;
            cnt_d    = '0;
            addr_d   = '0;
            nib_lo_d = 1'b0;
            fdo_d    = '0;
            fdoe_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (armed_q) begin
                        state_d = StCmd;
                        cnt_d   = '0;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        opcode_d = opcode_shift[6:0];
                        if (cnt_q == 8'd7) begin
                            cnt_d = '0;
                            if (opcode_shift == 8'hEB) begin
                                state_d = StAddr;
                            end else begin
                                state_d   = StIgnore;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        // Bits above MEM_AW fall off the top: the flash address wraps.
                        addr_d = {addr_q[MEM_AW-5:0], fdi_sync_q};
                        if (cnt_q == 8'd5) begin
                            cnt_d   = '0;
                            state_d = (MODE_CYC == 0) ? StDummy : StMode;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StMode: begin
                    if (sclk_rise) begin
                        if (cnt_q == ModeLast) begin
                            cnt_d   = '0;
                            state_d = StDummy;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StDummy: begin
                    if (sclk_rise) begin
                        if (cnt_q == DummyLast) begin
                            cnt_d      = '0;
                            state_d    = StData;
                            nib_lo_d   = 1'b0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_q;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StData: begin
                    if (sclk_fall) begin
                        fdoe_d = 1'b1;
                        if (!nib_lo_q) begin
                            fdo_d    = shift_q[7:4];
                            nib_lo_d = 1'b1;
                        end else begin
                            fdo_d      = shift_q[3:0];
                            nib_lo_d   = 1'b0;
                            addr_d     = addr_q + MEM_AW'(1);
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_q + MEM_AW'(1);
                        end
                    end
                end
                StIgnore: begin
                    fdoe_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cen_meta_q  <= 1'b1;
            cen_sync_q  <= 1'b1;
            fdi_meta_q  <= '0;
            fdi_sync_q  <= '0;
            sync_ok_q   <= '0;
            armed_q     <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            opcode_q    <= '0;
            addr_q      <= '0;
            shift_q     <= '0;
            nib_lo_q    <= 1'b0;
            load_q      <= 1'b0;
            fdo_q       <= '0;
            fdoe_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            sclk_meta_q <= fsclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cen_meta_q  <= fcen_i;
            cen_sync_q  <= cen_meta_q;
            fdi_meta_q  <= fdi_i;
            fdi_sync_q  <= fdi_meta_q;
            sync_ok_q   <= {sync_ok_q[0], 1'b1};
            // Only a genuine high level arms the decoder, so a low period spanning reset is ignored.
            armed_q     <= armed_q | (sync_ok_q[1] & cen_sync_q);
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            nib_lo_q    <= nib_lo_d;
            load_q      <= mem_rd_q;
            if (load_q) begin
                shift_q <= mem_data_i;
            end
            fdo_q       <= fdo_d;
            fdoe_q      <= fdoe_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign fdo_o      = fdo_q;
    assign fdoe_o     = fdoe_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign busy_o     = ~cen_sync_q;
    assign cmd_err_o  = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: a behavioural quad-SPI master plus byte-array flash model.
module tb_qspi_flash_responder;

    localparam int unsigned HALF  = 6;
    localparam int unsigned MODE  = 2;
    localparam int unsigned DUMMY = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fsclk;
    logic        fcen;
    logic [3:0]  fdi;
    logic [3:0]  fdo_o;
    logic        fdoe_o;
    logic        mem_rd_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_rdata;
    logic        busy_o;
    logic        cmd_err_o;

    logic [7:0]  mem [65536];
    logic [4:0]  obs_q [$];
    logic [15:0] rd_q [$];
    int          err_pulses;
    bit          fdoe_seen;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    qspi_flash_responder #(
        .MEM_AW   (16),
        .MODE_CYC (MODE),
        .DUMMY_CYC(DUMMY)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .fsclk_i   (fsclk),
        .fcen_i    (fcen),
        .fdi_i     (fdi),
        .fdo_o     (fdo_o),
        .fdoe_o    (fdoe_o),
        .mem_rd_o  (mem_rd_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_rdata),
        .busy_o    (busy_o),
        .cmd_err_o (cmd_err_o)
    );

    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata <= mem[mem_addr_o];
    end

    always @(negedge clk) begin
        if (mem_rd_o) rd_q.push_back(mem_addr_o);
        if (cmd_err_o) err_pulses++;
        if (fdoe_o) fdoe_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    // Reference: nibble k of a read starting at flash address a.
    function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
        logic [15:0] ba;
        logic [7:0]  b;
        ba = a[15:0] + 16'(k / 2);
        b  = mem[ba];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_cycle(input logic [3:0] nib);
        fdi = nib;
        tick(HALF);
        fsclk = 1'b1;
        tick(HALF);
        fsclk = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op);
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, op[i]});
    endtask

    task automatic send_header(input logic [23:0] a, input logic [3:0] mode);
        fcen = 1'b0;
        tick(HALF);
        send_cmd(8'hEB);
        for (int i = 5; i >= 0; i--) sclk_cycle(a[i*4 +: 4]);
        for (int i = 0; i < MODE; i++) sclk_cycle(mode);
        for (int i = 0; i < DUMMY; i++) sclk_cycle(4'($urandom));
    endtask

    task automatic read_nibbles(input int n);
        for (int k = 0; k < n; k++) begin
            tick(HALF);
            obs_q.push_back({fdoe_o, fdo_o});
            fsclk = 1'b1;
            tick(HALF);
            fsclk = 1'b0;
        end
    endtask

    task automatic end_txn;
        tick(HALF);
        fcen = 1'b1;
        tick(3 * HALF);
    endtask

    task automatic do_read(input logic [23:0] a, input int nbytes, input logic [3:0] mode);
        obs_q.delete();
        rd_q.delete();
        send_header(a, mode);
        read_nibbles(2 * nbytes);
        end_txn();
    endtask

    task automatic test_reset;
        rst = 1'b1; fcen = 1'b1; fsclk = 1'b0; fdi = 4'h0;
        tick(2);
        fcen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fsclk = ~fsclk;
            tick(1);
            checks++;
            if ({fdoe_o, mem_rd_o, busy_o, cmd_err_o, fdo_o} !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold%0d: oe/rd/busy/err/fdo got %h want 00", i,
                         {fdoe_o, mem_rd_o, busy_o, cmd_err_o, fdo_o});
            end
        end
        rst = 1'b0; fsclk = 1'b0; fcen = 1'b1;
        tick(6);
        checks++;
        if ({fdoe_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: oe/busy got %b want 00", {fdoe_o, busy_o});
        end
    endtask

    task automatic test_read;
        logic [23:0] a;
        a = 24'h000010;
        do_read(a, 4, 4'hF);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_q[k] !== {1'b1, exp_nib(a, k)}) begin
                errors++;
                $display("FAIL read_nib%0d: {oe,fdo} got %h want %h", k, obs_q[k],
                         {1'b1, exp_nib(a, k)});
            end
        end
        checks++;
        if (rd_q.size() != 5) begin
            errors++;
            $display("FAIL read_rdcount: got %0d want 5", rd_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rd_q[i] !== 16'(16'h0010 + i)) begin
                    errors++;
                    $display("FAIL read_addr%0d: got %h want %h", i, rd_q[i], 16'(16'h0010 + i));
                end
            end
        end
        checks++;
        if (fdoe_o !== 1'b0) begin
            errors++;
            $display("FAIL read_release: fdoe got %b want 0", fdoe_o);
        end
    endtask

    task automatic test_bad_opcode;
        logic [23:0] a;
        rd_q.delete(); err_pulses = 0; fdoe_seen = 1'b0;
        fcen = 1'b0;
        tick(HALF);
        send_cmd(8'h9F);
        for (int i = 0; i < 20; i++) sclk_cycle(4'($urandom));
        end_txn();
        checks++;
        if (err_pulses != 1) begin
            errors++;
            $display("FAIL bad_errpulse: got %0d want 1", err_pulses);
        end
        checks++;
        if (fdoe_seen || rd_q.size() != 0) begin
            errors++;
            $display("FAIL bad_quiet: oe_seen %0d reads %0d want 0 0", fdoe_seen, rd_q.size());
        end
        a = 24'($urandom);
        do_read(a, 2, 4'($urandom));
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k] !== {1'b1, exp_nib(a, k)}) begin
                errors++;
                $display("FAIL bad_next_nib%0d: got %h want %h", k, obs_q[k], {1'b1, exp_nib(a, k)});
            end
        end
    endtask

    task automatic test_abort;
        logic [23:0] a;
        rd_q.delete();
        fcen = 1'b0;
        tick(HALF);
        send_cmd(8'hEB);
        for (int i = 0; i < 3; i++) sclk_cycle(4'($urandom));
        fcen = 1'b1;
        tick(3);
        checks++;
        if ({fdoe_o, busy_o} !== 2'b00 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL abort_idle: oe/busy got %b reads %0d want 00 0", {fdoe_o, busy_o},
                     rd_q.size());
        end
        tick(3 * HALF);
        a = 24'h000100;
        do_read(a, 2, 4'h0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k] !== {1'b1, exp_nib(a, k)}) begin
                errors++;
                $display("FAIL abort_next_nib%0d: got %h want %h", k, obs_q[k],
                         {1'b1, exp_nib(a, k)});
            end
        end
    endtask

    task automatic test_wrap;
        logic [23:0] a;
        a = 24'h00FFFF;
        do_read(a, 2, 4'hA);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k] !== {1'b1, exp_nib(a, k)}) begin
                errors++;
                $display("FAIL wrap_nib%0d: got %h want %h", k, obs_q[k], {1'b1, exp_nib(a, k)});
            end
        end
        checks++;
        if (rd_q.size() != 3 || rd_q[0] !== 16'hFFFF || rd_q[1] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_addr: reads %0d first %h second %h want 3 ffff 0000", rd_q.size(),
                     rd_q[0], rd_q[1]);
        end
    endtask

    task automatic test_reset_mid_data;
        logic [23:0] a;
        a = 24'($urandom);
        obs_q.delete();
        send_header(a, 4'h3);
        read_nibbles(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({fdoe_o, fdo_o, mem_rd_o} !== 6'h00) begin
            errors++;
            $display("FAIL rstmid_outputs: oe/fdo/rd got %h want 00", {fdoe_o, fdo_o, mem_rd_o});
        end
        fdoe_seen = 1'b0; rd_q.delete(); err_pulses = 0;
        send_header(a, 4'h3);
        read_nibbles(4);
        checks++;
        if (fdoe_seen || rd_q.size() != 0 || err_pulses != 0) begin
            errors++;
            $display("FAIL rstmid_ignored: oe_seen %0d reads %0d errs %0d want 0 0 0", fdoe_seen,
                     rd_q.size(), err_pulses);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: got %b want 1", busy_o);
        end
        end_txn();
        do_read(a, 2, 4'h3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k] !== {1'b1, exp_nib(a, k)}) begin
                errors++;
                $display("FAIL rstmid_next_nib%0d: got %h want %h", k, obs_q[k],
                         {1'b1, exp_nib(a, k)});
            end
        end
    endtask

    task automatic test_random;
        logic [23:0] a;
        int          n;
        for (int it = 0; it < 6; it++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            err_pulses = 0;
            do_read(a, n, 4'($urandom));
            for (int k = 0; k < 2 * n; k++) begin
                checks++;
                if (obs_q[k] !== {1'b1, exp_nib(a, k)}) begin
                    errors++;
                    $display("FAIL rand%0d_nib%0d: addr %h got %h want %h", it, k, a, obs_q[k],
                             {1'b1, exp_nib(a, k)});
                end
            end
            checks++;
            if (rd_q.size() != n + 1 || rd_q[n] !== 16'(a[15:0] + 16'(n)) || err_pulses != 0) begin
                errors++;
                $display("FAIL rand%0d_reads: count %0d last %h errs %0d want %0d %h 0", it,
                         rd_q.size(), rd_q[rd_q.size()-1], err_pulses, n + 1,
                         16'(a[15:0] + 16'(n)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        err_pulses = 0;
        fdoe_seen  = 1'b0;
        test_reset();
        test_read();
        test_bad_opcode();
        test_abort();
        test_wrap();
        test_reset_mid_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
